// File: rtl/mul_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth digit code, packed as {neg, two, one}
  localparam logic [2:0] BOOTH_ZERO = 3'b000;
  localparam logic [2:0] BOOTH_P1   = 3'b001;
  localparam logic [2:0] BOOTH_P2   = 3'b010;
  localparam logic [2:0] BOOTH_M1   = 3'b101;
  localparam logic [2:0] BOOTH_M2   = 3'b110;

  function automatic int ext_width(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: 3-bit overlapping multiplier window to digit controls.
module booth_r4_encoder
  import mul_pkg::*;
(
  input  logic [2:0] window,
  output logic       neg,
  output logic       one,
  output logic       two
);

  logic [2:0] w_digit;

  // 111 maps to plain zero so a zero digit never requests negation
  always_comb begin
    w_digit = BOOTH_ZERO;
    case (window)
      3'b001, 3'b010: w_digit = BOOTH_P1;
      3'b011:         w_digit = BOOTH_P2;
      3'b100:         w_digit = BOOTH_M2;
      3'b101, 3'b110: w_digit = BOOTH_M1;
      default:        w_digit = BOOTH_ZERO;
    endcase
  end

  assign neg = w_digit[2];
  assign two = w_digit[1];
  assign one = w_digit[0];

endmodule

// File: rtl/booth_r4_seq_multiplier.sv
// Sequential radix-4 Booth multiplier, signed/unsigned per operation,
// start/busy/done handshake, two multiplier bits retired per cycle.
module booth_r4_seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int EW    = ext_width(WIDTH);
  localparam int ITERS = WIDTH / 2 + 1;
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic [EW-1:0]       r_a;
  logic [EW:0]         r_b;
  logic [2*EW-1:0]     r_acc;
  logic [2*WIDTH-1:0]  r_product;

  logic                w_accept, w_last;
  logic                w_neg, w_one, w_two;
  logic [EW-1:0]       w_mag, w_addend, w_sum;
  logic [2*EW-1:0]     w_acc_next;
  logic                w_a_sx, w_b_sx;

  booth_r4_encoder u_enc (
    .window (r_b[2:0]),
    .neg    (w_neg),
    .one    (w_one),
    .two    (w_two)
  );

  assign w_accept = start && (r_state != ITER);
  assign w_last   = (r_state == ITER) && (r_cnt == LAST);
  assign w_a_sx   = is_signed & multiplicand[WIDTH-1];
  assign w_b_sx   = is_signed & multiplier[WIDTH-1];

  // Negative digits use one's complement plus carry-in rather than a subtractor
  assign w_mag      = w_two ? {r_a[EW-2:0], 1'b0} : (w_one ? r_a : '0);
  assign w_addend   = w_neg ? ~w_mag : w_mag;
  assign w_sum      = r_acc[2*EW-1:EW] + w_addend + EW'(w_neg);
  assign w_acc_next = $signed({w_sum, r_acc[EW-1:0]}) >>> 2;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = ITER;
      ITER:    if (r_cnt == LAST) w_next = DONE;
      DONE:    w_next = start ? ITER : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a   <= {{2{w_a_sx}}, multiplicand};
        r_b   <= {{2{w_b_sx}}, multiplier, 1'b0};
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == ITER) begin
        r_acc <= w_acc_next;
        r_b   <= {{2{r_b[EW]}}, r_b[EW:2]};
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_product <= w_acc_next[2*WIDTH-1:0];
      end
    end
  end

  assign busy    = (r_state == ITER);
  assign done    = (r_state == DONE);
  assign product = r_product;

endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
// Directed and randomized checks of the Booth multiplier at WIDTH=32 and WIDTH=8.
module tb_booth_r4_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_signed;
  logic [31:0] multiplicand, multiplier;
  logic        busy, done;
  logic [63:0] product;

  logic        start8, is_signed8;
  logic [7:0]  multiplicand8, multiplier8;
  logic        busy8, done8;
  logic [15:0] product8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_r4_seq_multiplier #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product)
  );

  booth_r4_seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(is_signed8),
    .multiplicand(multiplicand8), .multiplier(multiplier8),
    .busy(busy8), .done(done8), .product(product8)
  );

  task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] p, output int lat, output int bcnt);
    int cyc;
    cyc = 0; bcnt = 0; lat = -1; p = '0;
    is_signed = s; multiplicand = a; multiplier = b; start = 1'b1;
    while (cyc < 100 && lat < 0) begin
      @(negedge clk); cyc++;
      if (cyc == 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin lat = cyc - 1; p = product; end
    end
  endtask

  task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] p, output int lat);
    int cyc;
    cyc = 0; lat = -1; p = '0;
    is_signed8 = s; multiplicand8 = a; multiplier8 = b; start8 = 1'b1;
    while (cyc < 50 && lat < 0) begin
      @(negedge clk); cyc++;
      if (cyc == 1) start8 = 1'b0;
      if (done8) begin lat = cyc - 1; p = product8; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; is_signed = 1'b0; multiplicand = '0; multiplier = '0;
    start8 = 1'b0; is_signed8 = 1'b0; multiplicand8 = '0; multiplier8 = '0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (product !== 64'h0) begin bad++; $display("FAIL reset_product got=%h want=0", product); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [63:0] p; int lat, bcnt;
    run32(1'b1, 32'd5, 32'd3, p, lat, bcnt);
    total++; if (lat !== 17) begin bad++; $display("FAIL basic_latency got=%0d want=17", lat); end
    total++; if (p !== 64'd15) begin bad++; $display("FAIL basic_product got=%0d want=15", p); end
    total++; if (bcnt !== 17) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=17", bcnt); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b want=0", done); end
  endtask

  task automatic test_signed_corners;
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [63:0] ve [3];
    logic [63:0] p; int lat, bcnt;
    va[0] = 32'h8000_0000; vb[0] = 32'h8000_0000; ve[0] = 64'h4000_0000_0000_0000;
    va[1] = 32'h7FFF_FFFF; vb[1] = 32'h8000_0000; ve[1] = 64'hC000_0000_8000_0000;
    va[2] = 32'h0;         vb[2] = 32'hFFFF_FFFF; ve[2] = 64'h0;
    for (int i = 0; i < 3; i++) begin
      run32(1'b1, va[i], vb[i], p, lat, bcnt);
      total++; if (lat !== 17) begin bad++; $display("FAIL corner%0d_latency got=%0d want=17", i, lat); end
      total++; if (p !== ve[i]) begin bad++; $display("FAIL corner%0d_product got=%h want=%h", i, p, ve[i]); end
    end
  endtask

  task automatic test_unsigned;
    logic [63:0] p; int lat, bcnt;
    run32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat, bcnt);
    total++; if (lat !== 17) begin bad++; $display("FAIL unsigned_latency got=%0d want=17", lat); end
    total++; if (p !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL unsigned_max got=%h want=fffffffe00000001", p); end
    run32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat, bcnt);
    total++; if (lat !== 17) begin bad++; $display("FAIL signed_m1_latency got=%0d want=17", lat); end
    total++; if (p !== 64'h1) begin bad++; $display("FAIL signed_m1_product got=%h want=1", p); end
  endtask

  task automatic test_ignore_start;
    logic [63:0] p, pmid; int lat, nd;
    nd = 0; lat = -1; p = '0; pmid = '0;
    is_signed = 1'b1; multiplicand = 32'd1234; multiplier = -32'sd5678; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 5) begin start = 1'b1; multiplicand = 32'd100; multiplier = 32'd100; is_signed = 1'b0; end
      if (c == 6) start = 1'b0;
      if (c == 10) pmid = product;
      if (done) begin nd++; if (nd == 1) begin p = product; lat = c - 1; end end
    end
    total++; if (pmid !== 64'h1) begin bad++; $display("FAIL ignore_product_held got=%h want=1", pmid); end
    total++; if (nd !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", nd); end
    total++; if (lat !== 17) begin bad++; $display("FAIL ignore_latency got=%0d want=17", lat); end
    total++; if (p !== 64'(-64'sd7006652)) begin bad++; $display("FAIL ignore_product got=%h want=-7006652", p); end
  endtask

  task automatic test_reset_mid;
    int nd;
    nd = 0;
    is_signed = 1'b0; multiplicand = 32'd1000; multiplier = 32'd1000; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midreset_busy_before got=%b want=1", busy); end
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b want=0", done); end
    total++; if (product !== 64'h0) begin bad++; $display("FAIL midreset_product got=%h want=0", product); end
    @(negedge clk);
    reset = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done) nd++;
    end
    total++; if (nd !== 0) begin bad++; $display("FAIL midreset_late_done got=%0d want=0", nd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] oa [3];
    logic [31:0] ob [3];
    logic [63:0] oe [3];
    logic [63:0] got [3];
    int dc [3];
    int nd, ld;
    logic pend;
    oa[0] = 32'd7;  ob[0] = 32'd6; oe[0] = 64'd42;
    oa[1] = -32'sd4; ob[1] = 32'd9; oe[1] = 64'(-64'sd36);
    oa[2] = 32'd2;  ob[2] = 32'd2; oe[2] = 64'd4;
    for (int i = 0; i < 3; i++) begin got[i] = '0; dc[i] = 0; end
    nd = 0; ld = 1; pend = 1'b1;
    is_signed = 1'b1; multiplicand = oa[0]; multiplier = ob[0]; start = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (pend) begin
        if (ld < 3) begin multiplicand = oa[ld]; multiplier = ob[ld]; end
        else start = 1'b0;
        ld++; pend = 1'b0;
      end
      if (done) begin
        if (nd < 3) begin got[nd] = product; dc[nd] = c; end
        nd++; pend = 1'b1;
      end
    end
    start = 1'b0;
    total++; if (nd !== 3) begin bad++; $display("FAIL b2b_done_count got=%0d want=3", nd); end
    for (int i = 0; i < 3; i++) begin
      total++; if (got[i] !== oe[i]) begin bad++; $display("FAIL b2b_product%0d got=%h want=%h", i, got[i], oe[i]); end
    end
    total++; if (dc[1] - dc[0] !== 18) begin bad++; $display("FAIL b2b_spacing01 got=%0d want=18", dc[1] - dc[0]); end
    total++; if (dc[2] - dc[1] !== 18) begin bad++; $display("FAIL b2b_spacing12 got=%0d want=18", dc[2] - dc[1]); end
  endtask

  task automatic test_random;
    logic [31:0] a, b; logic s;
    logic [63:0] ea, eb, ex, p; int lat, bcnt;
    logic [7:0] a8, b8;
    logic [15:0] ea8, eb8, ex8, p8;
    for (int i = 0; i < 200; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      ea = s ? {{32{a[31]}}, a} : {32'h0, a};
      eb = s ? {{32{b[31]}}, b} : {32'h0, b};
      ex = ea * eb;
      run32(s, a, b, p, lat, bcnt);
      total++;
      if (p !== ex || lat !== 17) begin
        bad++; $display("FAIL rand32_%0d s=%b a=%h b=%h got=%h lat=%0d want=%h lat=17", i, s, a, b, p, lat, ex);
      end
    end
    for (int i = 0; i < 200; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); s = 1'($urandom_range(0, 1));
      ea8 = s ? {{8{a8[7]}}, a8} : {8'h0, a8};
      eb8 = s ? {{8{b8[7]}}, b8} : {8'h0, b8};
      ex8 = ea8 * eb8;
      run8(s, a8, b8, p8, lat);
      total++;
      if (p8 !== ex8 || lat !== 5) begin
        bad++; $display("FAIL rand8_%0d s=%b a=%h b=%h got=%h lat=%0d want=%h lat=5", i, s, a8, b8, p8, lat, ex8);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signed_corners;
    test_unsigned;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
